// File: rtl/decode_stage.sv
// RISC-V RV32I/RV64I decode stage with a micro-op FIFO between fetch and issue.
// Define RV_M_EXT_EN to decode the M extension; otherwise those encodings are illegal.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic             rd_v_o,
    output logic             rs1_v_o,
    output logic             rs2_v_o,
    output logic [XLEN-1:0]  imm_o,
    output logic             rs2_is_imm_o,
    output logic [2:0]       unit_o,
    output logic [3:0]       op_o,
    output logic             word_o,
    output logic [11:0]      csr_o,
    output logic             illegal_o
);

`ifdef RV_M_EXT_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    localparam logic [2:0] UNIT_ALU = 3'd0;
    localparam logic [2:0] UNIT_BR  = 3'd1;
    localparam logic [2:0] UNIT_LSU = 3'd2;
    localparam logic [2:0] UNIT_CSR = 3'd3;
    localparam logic [2:0] UNIT_MD  = 3'd4;
    localparam logic [2:0] UNIT_SYS = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_v;
        logic            rs1_v;
        logic            rs2_v;
        logic [XLEN-1:0] imm;
        logic            rs2_is_imm;
        logic [2:0]      unit;
        logic [3:0]      op;
        logic            word;
        logic [11:0]     csr;
        logic            illegal;
    } uop_t;

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               is64;
    logic               shamt_ok;
    logic               shamt_w_ok;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign is64  = (XLEN == 64);
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // RV64 shift amounts take one extra bit out of the funct7 field.
    assign shamt_ok = is64 ? (instr_i[31:26] == 6'b000000 || instr_i[31:26] == 6'b010000)
                           : (f7 == 7'b0000000 || f7 == 7'b0100000);
    assign shamt_w_ok = (f7 == 7'b0000000 || f7 == 7'b0100000);

    uop_t dec;
    logic legal;

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        unique case (opc)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1; dec.unit = UNIT_ALU; dec.rd_v = 1'b1;
                dec.rs2_is_imm = 1'b1; dec.imm = XLEN'(imm_u);
            end
            OPC_JAL: begin
                legal = 1'b1; dec.unit = UNIT_BR; dec.rd_v = 1'b1; dec.imm = XLEN'(imm_j);
            end
            OPC_JALR: begin
                legal = 1'b1; dec.unit = UNIT_BR; dec.rd_v = 1'b1; dec.rs1_v = 1'b1;
                dec.rs2_is_imm = 1'b1; dec.imm = XLEN'(imm_i); dec.op = {1'b0, f3};
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                dec.unit = UNIT_BR; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1;
                dec.imm = XLEN'(imm_b); dec.op = {1'b0, f3};
            end
            OPC_LOAD: begin
                legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                        || (is64 && (f3 inside {3'b011, 3'b110}));
                dec.unit = UNIT_LSU; dec.rd_v = 1'b1; dec.rs1_v = 1'b1;
                dec.rs2_is_imm = 1'b1; dec.imm = XLEN'(imm_i); dec.op = {1'b0, f3};
            end
            OPC_STORE: begin
                legal = (f3 inside {3'b000, 3'b001, 3'b010}) || (is64 && f3 == 3'b011);
                dec.unit = UNIT_LSU; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1;
                dec.rs2_is_imm = 1'b1; dec.imm = XLEN'(imm_s); dec.op = {1'b0, f3};
            end
            OPC_OPIMM, OPC_OPIMMW: begin
                if (opc == OPC_OPIMM) begin
                    legal = (f3[1:0] == 2'b01) ? shamt_ok : 1'b1;
                end else begin
                    legal = is64 && (f3 == 3'b000 || ((f3 == 3'b001 || f3 == 3'b101) && shamt_w_ok));
                    dec.word = 1'b1;
                end
                dec.unit = UNIT_ALU; dec.rd_v = 1'b1; dec.rs1_v = 1'b1;
                dec.rs2_is_imm = 1'b1; dec.imm = XLEN'(imm_i);
                dec.op = {(f3[1:0] == 2'b01) ? instr_i[30] : 1'b0, f3};
            end
            OPC_OP, OPC_OPW: begin
                dec.rd_v = 1'b1; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1;
                dec.word = (opc == OPC_OPW);
                if (f7 == 7'b0000001) begin
                    dec.unit = UNIT_MD; dec.op = {1'b0, f3};
                    legal = M_EN && ((opc == OPC_OP)
                            || (is64 && (f3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111})));
                end else begin
                    dec.unit = UNIT_ALU; dec.op = {instr_i[30], f3};
                    if (opc == OPC_OP) begin
                        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                    end else begin
                        legal = is64 && ((f7 == 7'b0000000 && (f3 inside {3'b000, 3'b001, 3'b101}))
                                || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                    end
                end
            end
            OPC_FENCE: begin
                legal = 1'b1; dec.unit = UNIT_SYS; dec.op = {1'b0, f3};
            end
            OPC_SYSTEM: begin
                dec.csr = instr_i[31:20]; dec.op = {1'b0, f3};
                if (f3 == 3'b000) begin
                    legal = (instr_i[19:7] == 13'd0)
                            && (instr_i[31:20] inside {12'h000, 12'h001, 12'h302, 12'h102});
                    dec.unit = UNIT_SYS; dec.csr = '0; dec.op = {1'b0, instr_i[22:20]};
                end else if (f3 == 3'b100) begin
                    legal = 1'b0;
                end else begin
                    legal = 1'b1; dec.unit = UNIT_CSR; dec.rd_v = 1'b1;
                    dec.rs1_v = ~f3[2];
                    dec.imm = f3[2] ? XLEN'(instr_i[19:15]) : '0;
                end
            end
            default: legal = 1'b0;
        endcase

        dec.rd_v  = dec.rd_v && (instr_i[11:7] != 5'd0);
        dec.rd    = dec.rd_v  ? instr_i[11:7]  : 5'd0;
        dec.rs1   = dec.rs1_v ? instr_i[19:15] : 5'd0;
        dec.rs2   = dec.rs2_v ? instr_i[24:20] : 5'd0;

        if (!legal) begin
            dec         = '0;
            dec.unit    = UNIT_SYS;
            dec.illegal = 1'b1;
        end
        dec.pc = pc_i;
    end

    uop_t           mem_q [DEPTH];
    uop_t           mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push, pop;
    uop_t           head;

    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign pc_o         = head.pc;
    assign rd_o         = head.rd;
    assign rs1_o        = head.rs1;
    assign rs2_o        = head.rs2;
    assign rd_v_o       = head.rd_v;
    assign rs1_v_o      = head.rs1_v;
    assign rs2_v_o      = head.rs2_v;
    assign imm_o        = head.imm;
    assign rs2_is_imm_o = head.rs2_is_imm;
    assign unit_o       = head.unit;
    assign op_o         = head.op;
    assign word_o       = head.word;
    assign csr_o        = head.csr;
    assign illegal_o    = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage at XLEN=32, DEPTH=2.
module tb_decode_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rd_o, rs1_o, rs2_o;
    logic            rd_v_o, rs1_v_o, rs2_v_o;
    logic [XLEN-1:0] imm_o;
    logic            rs2_is_imm_o;
    logic [2:0]      unit_o;
    logic [3:0]      op_o;
    logic            word_o;
    logic [11:0]     csr_o;
    logic            illegal_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_v_o(rd_v_o), .rs1_v_o(rs1_v_o), .rs2_v_o(rs2_v_o),
        .imm_o(imm_o), .rs2_is_imm_o(rs2_is_imm_o), .unit_o(unit_o),
        .op_o(op_o), .word_o(word_o), .csr_o(csr_o), .illegal_o(illegal_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag,
                           input logic [4:0] rd,  input logic rd_v,
                           input logic [4:0] rs1, input logic rs1_v,
                           input logic [4:0] rs2, input logic rs2_v,
                           input logic [31:0] imm, input logic rs2imm,
                           input logic [2:0] unit, input logic [3:0] op,
                           input logic ill);
        chk({tag, ".valid"},  64'(out_valid_o),  64'(1'b1));
        chk({tag, ".rd"},     64'(rd_o),         64'(rd));
        chk({tag, ".rd_v"},   64'(rd_v_o),       64'(rd_v));
        chk({tag, ".rs1"},    64'(rs1_o),        64'(rs1));
        chk({tag, ".rs1_v"},  64'(rs1_v_o),      64'(rs1_v));
        chk({tag, ".rs2"},    64'(rs2_o),        64'(rs2));
        chk({tag, ".rs2_v"},  64'(rs2_v_o),      64'(rs2_v));
        chk({tag, ".imm"},    64'(imm_o),        64'(imm));
        chk({tag, ".rs2imm"}, 64'(rs2_is_imm_o), 64'(rs2imm));
        chk({tag, ".unit"},   64'(unit_o),       64'(unit));
        chk({tag, ".op"},     64'(op_o),         64'(op));
        chk({tag, ".ill"},    64'(illegal_o),    64'(ill));
    endtask

    // Offers one instruction for a single edge; on return the entry is at the head.
    task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
        in_valid_i = 1'b1;
        instr_i    = ins;
        pc_i       = pc;
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        instr_i = '0; pc_i = '0; out_ready_i = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst.valid", 64'(out_valid_o), 64'd0);
        chk("rst.ready", 64'(in_ready_o),  64'd1);
        chk("rst.pc",    64'(pc_o),        64'd0);
        chk("rst.unit",  64'(unit_o),      64'd0);
        chk("rst.imm",   64'(imm_o),       64'd0);
        chk("rst.ill",   64'(illegal_o),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        push1(32'hFFF00093, 32'h1000);
        chk_dec("addi", 5'd1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 3'd0, 4'h0, 1'b0);
        chk("addi.pc",   64'(pc_o),   64'h1000);
        chk("addi.csr",  64'(csr_o),  64'd0);
        chk("addi.word", 64'(word_o), 64'd0);

        push1(32'h123452B7, 32'h1004);
        chk_dec("lui", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h12345000, 1'b1, 3'd0, 4'h0, 1'b0);
        chk("lui.pc", 64'(pc_o), 64'h1004);

        push1(32'h0000B083, 32'h1008);
        chk_dec("ld32", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd5, 4'h0, 1'b1);
        chk("ld32.pc", 64'(pc_o), 64'h1008);

        push1(32'h022081B3, 32'h100C);
`ifdef RV_M_EXT_EN
        chk_dec("mul", 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 32'h0, 1'b0, 3'd4, 4'h0, 1'b0);
`else
        chk_dec("mul", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd5, 4'h0, 1'b1);
`endif

        push1(32'hFE209EE3, 32'h1010);
        chk_dec("bne", 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'hFFFFFFFC, 1'b0, 3'd1, 4'h1, 1'b0);

        push1(32'h4041D113, 32'h1014);
        chk_dec("srai", 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 32'h00000404, 1'b1, 3'd0, 4'hD, 1'b0);

        push1(32'h02009093, 32'h1018);
        chk_dec("slli_bad", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd5, 4'h0, 1'b1);

        push1(32'h0020A423, 32'h101C);
        chk_dec("sw", 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h8, 1'b1, 3'd2, 4'h2, 1'b0);

        push1(32'h3003D2F3, 32'h1020);
        chk_dec("csrrwi", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h7, 1'b0, 3'd3, 4'h5, 1'b0);
        chk("csrrwi.csr", 64'(csr_o), 64'h300);

        push1(32'h00000073, 32'h1024);
        chk_dec("ecall", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd5, 4'h0, 1'b0);

        push1(32'h30200073, 32'h1028);
        chk_dec("mret", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd5, 4'h2, 1'b0);
        chk("mret.csr", 64'(csr_o), 64'd0);

        push1(32'h00208033, 32'h102C);
        chk_dec("add_x0", 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h0, 1'b0, 3'd0, 4'h0, 1'b0);

        @(negedge clk);
        chk("drain.valid", 64'(out_valid_o), 64'd0);

        // Backpressure: three offers into a two-entry FIFO.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; instr_i = 32'hFFF00093; pc_i = 32'h100;
        chk("bp.ready0", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        chk("bp.valid1", 64'(out_valid_o), 64'd1);
        chk("bp.pc1",    64'(pc_o),        64'h100);
        chk("bp.ready1", 64'(in_ready_o),  64'd1);
        instr_i = 32'h123452B7; pc_i = 32'h104;
        @(negedge clk);
        chk("bp.full", 64'(in_ready_o), 64'd0);
        instr_i = 32'hFE209EE3; pc_i = 32'h108;
        @(negedge clk);
        chk("bp.full2", 64'(in_ready_o), 64'd0);
        chk("bp.head",  64'(pc_o),       64'h100);
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp.pop1.pc",    64'(pc_o),       64'h104);
        chk("bp.pop1.ready", 64'(in_ready_o), 64'd1);
        chk("bp.pop1.rd",    64'(rd_o),       64'd5);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("bp.pop2.pc",   64'(pc_o),        64'h108);
        chk("bp.pop2.unit", 64'(unit_o),      64'd1);
        chk("bp.pop2.v",    64'(out_valid_o), 64'd1);
        @(negedge clk);
        chk("bp.empty", 64'(out_valid_o), 64'd0);

        // Flush with the FIFO full and an input offered.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; instr_i = 32'h0020A423; pc_i = 32'h200;
        @(negedge clk);
        pc_i = 32'h204;
        @(negedge clk);
        chk("fl.full", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1; pc_i = 32'h208; instr_i = 32'h00000073;
        @(negedge clk);
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl.valid", 64'(out_valid_o), 64'd0);
        chk("fl.ready", 64'(in_ready_o),  64'd1);
        @(negedge clk);
        chk("fl.dropped", 64'(out_valid_o), 64'd0);

        // Flush with room available: the offered input must still be dropped.
        push1(32'h123452B7, 32'h300);
        chk("fl2.pre", 64'(pc_o), 64'h300);
        in_valid_i = 1'b1; flush_i = 1'b1; instr_i = 32'hFFF00093; pc_i = 32'h304;
        @(negedge clk);
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("fl2.valid", 64'(out_valid_o), 64'd0);
        push1(32'h0020A423, 32'h20C);
        chk("fl2.after.pc",   64'(pc_o),   64'h20C);
        chk("fl2.after.unit", 64'(unit_o), 64'd2);

        // Asynchronous reset between clock edges.
        push1(32'hFE209EE3, 32'h400);
        chk("ar.pre", 64'(out_valid_o), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar.valid", 64'(out_valid_o), 64'd0);
        chk("ar.ready", 64'(in_ready_o),  64'd1);
        chk("ar.pc",    64'(pc_o),        64'd0);
        chk("ar.rs1",   64'(rs1_o),       64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
